// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: shared widths, zero-register address and FIFO entry type for the writeback stage
package writeback_stage_pkg;
  localparam int WB_DATA_W = 64;
  localparam int WB_ADDR_W = 5;
  localparam logic [WB_ADDR_W-1:0] XZR_ADDR = WB_ADDR_W'(31);
  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_ADDR_W-1:0] dest;
    logic                 regwrite;
  } wb_entry_t;
endpackage

// File: rtl/writeback_stage_fwd_mux.sv
// wb_fwd_mux: single read-port bypass over the two pending writeback entries, younger entry wins
module wb_fwd_mux
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic [ADDR_W-1:0] sa,
  input  logic [DATA_W-1:0] rf,
  input  wb_entry_t         older,
  input  logic              older_v,
  input  wb_entry_t         younger,
  input  logic              younger_v,
  output logic [DATA_W-1:0] fwd
);
  logic hit_o, hit_y;
  assign hit_o = older_v && older.regwrite && older.dest == sa;
  assign hit_y = younger_v && younger.regwrite && younger.dest == sa;
  assign fwd = sa == XZR_ADDR ? '0 : hit_y ? younger.data : hit_o ? older.data : rf;
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: 2-entry result FIFO driving the register-file write port; WB_FORWARD_EN adds read bypass
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              hold,
  output logic [DATA_W-1:0] D,
  output logic [ADDR_W-1:0] DA,
  output logic              W,
  input  logic [ADDR_W-1:0] SA,
  input  logic [ADDR_W-1:0] SB,
  input  logic [DATA_W-1:0] A_rf,
  input  logic [DATA_W-1:0] B_rf,
  output logic [DATA_W-1:0] A_fwd,
  output logic [DATA_W-1:0] B_fwd
);
  wb_entry_t ent0, ent1, n0, n1, in_ent, s0;
  logic v0, v1, nv0, nv1, sv0, push, pop;
  assign in_ent = '{data: in_memtoreg ? in_mem : in_alu, dest: in_dest, regwrite: in_regwrite};
  assign in_ready = !v1;
  assign push = in_valid && in_ready;
  assign pop = v0 && !hold;
  // shift on pop first, then drop the new entry into the first free slot
  always_comb begin
    s0 = pop ? ent1 : ent0;
    sv0 = pop ? v1 : v0;
    n0 = push && !sv0 ? in_ent : s0;
    nv0 = sv0 || push;
    n1 = push && sv0 ? in_ent : pop ? '0 : ent1;
    nv1 = push && sv0 ? 1'b1 : pop ? 1'b0 : v1;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      ent0 <= '0;
      ent1 <= '0;
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else begin
      ent0 <= n0;
      ent1 <= n1;
      v0 <= nv0;
      v1 <= nv1;
    end
  assign D = v0 ? ent0.data : '0;
  assign DA = v0 ? ent0.dest : '0;
  assign W = v0 && ent0.regwrite && ent0.dest != XZR_ADDR && !hold;
`ifdef WB_FORWARD_EN
  wb_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
    .sa(SA), .rf(A_rf), .older(ent0), .older_v(v0), .younger(ent1), .younger_v(v1), .fwd(A_fwd)
  );
  wb_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
    .sa(SB), .rf(B_rf), .older(ent0), .older_v(v0), .younger(ent1), .younger_v(v1), .fwd(B_fwd)
  );
`else
  logic unused_sel;
  assign unused_sel = ^{SA, SB};
  assign A_fwd = A_rf;
  assign B_fwd = B_rf;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed stimulus with a queue scoreboard checked by a negedge monitor
module tb_writeback_stage;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_memtoreg = 0, in_regwrite = 0, hold = 0, in_ready, W;
  logic [63:0] in_alu = 0, in_mem = 0, D, A_rf = 0, B_rf = 0, A_fwd, B_fwd;
  logic [4:0] in_dest = 0, DA, SA = 0, SB = 0;
  int checks = 0, errors = 0;
  typedef struct {logic [63:0] d; logic [4:0] a; logic rw;} exp_t;
  exp_t q[$];
  exp_t e;

  writeback_stage dut (
    .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_alu(in_alu),
    .in_mem(in_mem), .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .in_dest(in_dest),
    .hold(hold), .D(D), .DA(DA), .W(W), .SA(SA), .SB(SB), .A_rf(A_rf), .B_rf(B_rf),
    .A_fwd(A_fwd), .B_fwd(B_fwd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  // head of the queue is what the FIFO must present; it leaves on any cycle without hold
  always @(negedge clk)
    if (q.size() == 0) chk("empty", {W, DA, D}, 70'h0);
    else begin
      e = q[0];
      chk(hold ? "held" : "write", {W, DA, D}, {!hold && e.rw && e.a != 5'd31, e.a, e.d});
      if (!hold) void'(q.pop_front());
    end

  task automatic step(input logic v, input logic [63:0] alu, input logic [63:0] mem,
                      input logic m2r, input logic rw, input logic [4:0] dst, input logic h);
    logic acc;
    exp_t x;
    in_valid = v; in_alu = alu; in_mem = mem; in_memtoreg = m2r;
    in_regwrite = rw; in_dest = dst; hold = h;
    chk("in_ready", in_ready, q.size() < 2);
    acc = v && q.size() < 2;
    x.d = m2r ? mem : alu; x.a = dst; x.rw = rw;
    @(posedge clk);
    if (acc) q.push_back(x);
    #1;
    in_valid = 0;
  endtask

  task automatic idle(input int n, input logic h);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, h);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_ready", in_ready, 1);
    chk("rst_out", {W, DA, D}, 70'h0);
    step(1, 64'h1234, 0, 0, 1, 5, 0);
    idle(2, 0);
    step(1, 64'h30, 0, 0, 1, 3, 1);
    step(1, 64'h70, 0, 0, 1, 7, 1);
    step(1, 64'h90, 0, 0, 1, 9, 1);
    SA = 3; A_rf = 64'h77; SB = 7; B_rf = 64'h88;
    #1;
`ifdef WB_FORWARD_EN
    chk("fwd_a_old", A_fwd, 64'h30);
    chk("fwd_b_young", B_fwd, 64'h70);
`else
    chk("fwd_a_old", A_fwd, 64'h77);
    chk("fwd_b_young", B_fwd, 64'h88);
`endif
    idle(3, 0);
    step(1, 64'h5, 64'hDEAD, 1, 1, 31, 0);
    SA = 31; A_rf = 64'hFFFF;
    #1;
`ifdef WB_FORWARD_EN
    chk("fwd_xzr", A_fwd, 64'h0);
`else
    chk("fwd_xzr", A_fwd, 64'hFFFF);
`endif
    idle(2, 0);
    step(1, 64'hA, 0, 0, 1, 4, 1);
    step(1, 64'hB, 0, 0, 1, 4, 1);
    SA = 4; A_rf = 64'h0; SB = 9; B_rf = 64'h55;
    #1;
`ifdef WB_FORWARD_EN
    chk("fwd_youngest", A_fwd, 64'hB);
`else
    chk("fwd_youngest", A_fwd, 64'h0);
`endif
    chk("fwd_miss", B_fwd, 64'h55);
    idle(3, 0);
    step(1, 64'h100, 0, 0, 1, 10, 1);
    step(1, 64'h110, 0, 0, 1, 11, 1);
    rst_n = 0;
    #1;
    chk("midrst_out", {W, DA, D}, 70'h0);
    chk("midrst_ready", in_ready, 1);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1;
    idle(3, 0);
    step(1, 64'h1, 0, 0, 0, 1, 1);
    step(1, 64'h2, 0, 0, 0, 2, 1);
    for (int i = 0; i < 6; i++) step(1, 64'h40 + 64'(i), 0, 0, 0, 5'(i + 3), 0);
    idle(4, 0);
    chk("drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
